// File: rtl/cpu_pkg.sv
// Shared CPU definitions: constant-register state encoding and extension mode codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    CR_EMPTY   = 2'd0,
    CR_PARTIAL = 2'd1,
    CR_FULL    = 2'd2
  } cr_state_e;

  localparam logic CR_EXT_ZERO = 1'b0;
  localparam logic CR_EXT_SIGN = 1'b1;

endpackage

// File: rtl/cr_ext_mux.sv
// Per-slot byte select: the loaded byte if this slot has been written, else the extension byte.
module cr_ext_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PTR_W    = 2,
  parameter int SLOT_IDX = 0
) (
  input  logic [DATA_W-1:0] slot_i,
  input  logic [PTR_W-1:0]  wr_ptr_i,
  input  logic              last_msb_i,
  input  logic              sext_i,
  output logic [DATA_W-1:0] byte_o
);

  logic [DATA_W-1:0] ext_byte;

  // With nothing loaded there is no sign bit to copy, so extension is always zero.
  always_comb begin
    ext_byte = '0;
    if (sext_i == CR_EXT_SIGN && wr_ptr_i != '0) begin
      ext_byte = {DATA_W{last_msb_i}};
    end
  end

  always_comb begin
    byte_o = ext_byte;
    if (PTR_W'(SLOT_IDX) < wr_ptr_i) begin
      byte_o = slot_i;
    end
  end

endmodule

// File: rtl/constant_register_multi.sv
// Multi-byte immediate constant register: assembles operand bytes from the instruction
// stream and presents the extended constant byte-by-byte on the tri-state main bus.
module constant_register_multi
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NBYTES = 2,
  localparam int PTR_W = $clog2(NBYTES + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  inout  wire  [DATA_W-1:0]        main_bus,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     load_n,
  input  logic                     a_main_n,
  input  logic                     clr_n,
  input  logic                     sext,
  output logic [NBYTES*DATA_W-1:0] const_value,
  output logic                     const_empty,
  output logic                     const_full,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  logic [DATA_W-1:0] slot_q [NBYTES];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  cr_state_e         state_q;
  logic              overflow_q;

  // Post-clear view of the state: a clear takes effect before a same-cycle load.
  logic [PTR_W-1:0]  wr_base;
  cr_state_e         state_base;
  logic              overflow_base;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_d;
  cr_state_e         state_d;
  logic              overflow_d;
  logic              slot_we;

  always_comb begin
    wr_base       = clr_n ? wr_ptr_q : '0;
    state_base    = clr_n ? state_q : CR_EMPTY;
    overflow_base = clr_n ? overflow_q : 1'b0;
    wr_ptr_d      = wr_base;
    state_d       = state_base;
    overflow_d    = overflow_base;
    slot_we       = 1'b0;
    if (!load_n) begin
      if (state_base == CR_FULL) begin
        overflow_d = 1'b1;
      end else begin
        slot_we  = 1'b1;
        wr_ptr_d = wr_base + 1'b1;
        state_d  = (wr_ptr_d == PTR_W'(NBYTES)) ? CR_FULL : CR_PARTIAL;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (!clr_n) begin
      rd_ptr_d = '0;
    end else if (!a_main_n) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(NBYTES - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NBYTES; i++) slot_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= CR_EMPTY;
      overflow_q <= 1'b0;
    end else begin
      if (slot_we) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (PTR_W'(i) == wr_base) slot_q[i] <= mem_data;
        end
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Sign bit of the most recently loaded byte drives the extension.
  logic last_msb;
  always_comb begin
    last_msb = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (PTR_W'(i + 1) == wr_ptr_q) last_msb = slot_q[i][DATA_W-1];
    end
  end

  logic [DATA_W-1:0] ext_bytes [NBYTES];

  for (genvar g = 0; g < NBYTES; g++) begin : g_slot
    cr_ext_mux #(
      .DATA_W  (DATA_W),
      .PTR_W   (PTR_W),
      .SLOT_IDX(g)
    ) u_ext_mux (
      .slot_i    (slot_q[g]),
      .wr_ptr_i  (wr_ptr_q),
      .last_msb_i(last_msb),
      .sext_i    (sext),
      .byte_o    (ext_bytes[g])
    );
    assign const_value[g*DATA_W +: DATA_W] = ext_bytes[g];
  end

  logic [DATA_W-1:0] bus_byte;
  always_comb begin
    bus_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (PTR_W'(i) == rd_ptr_q) bus_byte = ext_bytes[i];
    end
  end

  assign main_bus    = a_main_n ? {DATA_W{1'bz}} : bus_byte;
  assign const_empty = (state_q == CR_EMPTY);
  assign const_full  = (state_q == CR_FULL);
  assign overflow    = overflow_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_constant_register_multi.sv
// Bench for constant_register_multi: directed cases plus random stimulus against a byte-list model.
module tb_constant_register_multi;
  import cpu_pkg::*;

  localparam int DW = 8;
  localparam int NB = 2;

  logic            clk;
  logic            reset_n;
  wire  [DW-1:0]   main_bus;
  logic [DW-1:0]   mem_data;
  logic            load_n;
  logic            a_main_n;
  logic            clr_n;
  logic            sext;
  logic [NB*DW-1:0] const_value;
  logic            const_empty;
  logic            const_full;
  logic            overflow;
  logic [1:0]      dbg_state;

  constant_register_multi #(.DATA_W(DW), .NBYTES(NB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .main_bus   (main_bus),
    .mem_data   (mem_data),
    .load_n     (load_n),
    .a_main_n   (a_main_n),
    .clr_n      (clr_n),
    .sext       (sext),
    .const_value(const_value),
    .const_empty(const_empty),
    .const_full (const_full),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: list of loaded bytes, read index, sticky overflow.
  logic [DW-1:0] m_bytes [NB];
  int            m_cnt;
  int            m_rd;
  logic          m_ovf;

  function automatic logic [DW-1:0] m_byte(input int i, input logic sx);
    if (i < m_cnt) return m_bytes[i];
    if (sx && m_cnt > 0 && m_bytes[m_cnt-1][DW-1]) return '1;
    return '0;
  endfunction

  function automatic logic [NB*DW-1:0] m_const(input logic sx);
    logic [NB*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[i*DW +: DW] = m_byte(i, sx);
    return v;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_cnt == 0) return CR_EMPTY;
    if (m_cnt == NB) return CR_FULL;
    return CR_PARTIAL;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".const"}, 32'(const_value), 32'(m_const(sext)));
    check({tag, ".empty"}, 32'(const_empty), 32'(m_cnt == 0));
    check({tag, ".full"},  32'(const_full),  32'(m_cnt == NB));
    check({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
    check({tag, ".state"}, 32'(dbg_state),   32'(m_state()));
  endtask

  // driver: one clock cycle with the given controls, checks bus before and state after the edge
  task automatic cycle(input string tag, input logic ld, input logic [DW-1:0] d,
                       input logic rd, input logic clr, input logic sx);
    logic [DW-1:0] exp_bus;
    logic [DW-1:0] zbus;
    mem_data = d;
    load_n   = ~ld;
    a_main_n = ~rd;
    clr_n    = ~clr;
    sext     = sx;
    #1;
    zbus = 'z;
    exp_bus = rd ? m_byte(m_rd, sx) : zbus;
    check({tag, ".bus"}, {24'h0, main_bus}, {24'h0, exp_bus});
    @(posedge clk);
    if (clr) begin
      m_cnt = 0; m_rd = 0; m_ovf = 1'b0;
    end else if (rd) begin
      m_rd = (m_rd + 1) % NB;
    end
    if (ld) begin
      if (m_cnt == NB) m_ovf = 1'b1;
      else begin
        m_bytes[m_cnt] = d;
        m_cnt++;
      end
    end
    #1;
    check_outputs(tag);
    load_n = 1'b1; a_main_n = 1'b1; clr_n = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    logic [DW-1:0] zbus;
    reset_n = 1'b0;
    load_n = 1'b1; a_main_n = 1'b1; clr_n = 1'b1;
    @(posedge clk);
    #1;
    m_cnt = 0; m_rd = 0; m_ovf = 1'b0;
    for (int i = 0; i < NB; i++) m_bytes[i] = '0;
    zbus = 'z;
    check({tag, ".bus_z"}, {24'h0, main_bus}, {24'h0, zbus});
    reset_n = 1'b1;
    check_outputs(tag);
  endtask

  initial begin
    reset_n = 1'b0; mem_data = '0; load_n = 1'b1; a_main_n = 1'b1;
    clr_n = 1'b1; sext = 1'b0;
    @(posedge clk);
    do_reset("rst");

    cycle("rd_empty", 0, 8'h00, 1, 0, 0);
    cycle("clr0", 0, 8'h00, 0, 1, 0);

    cycle("ld34", 1, 8'h34, 0, 0, 0);
    cycle("ld12", 1, 8'h12, 0, 0, 0);
    check("c1234", 32'(const_value), 32'h1234);
    cycle("rd_lo", 0, 8'h00, 1, 0, 0);
    cycle("rd_hi", 0, 8'h00, 1, 0, 0);
    cycle("rd_wrap", 0, 8'h00, 1, 0, 0);

    cycle("clr1", 0, 8'h00, 0, 1, 0);
    cycle("ld85", 1, 8'h85, 0, 0, 1);
    check("cff85", 32'(const_value), 32'hFF85);
    cycle("rd85", 0, 8'h00, 1, 0, 1);
    cycle("rdff", 0, 8'h00, 1, 0, 1);
    cycle("rd85z", 0, 8'h00, 1, 0, 0);
    cycle("rd00", 0, 8'h00, 1, 0, 0);
    check("c0085", 32'(const_value), 32'h0085);

    cycle("clr2", 0, 8'h00, 0, 1, 0);
    cycle("ldef", 1, 8'hEF, 0, 0, 0);
    cycle("ldbe", 1, 8'hBE, 0, 0, 0);
    cycle("ld99", 1, 8'h99, 0, 0, 0);
    check("cbeef", 32'(const_value), 32'hBEEF);
    check("ovf1", 32'(overflow), 32'h1);
    cycle("clr3", 0, 8'h00, 0, 1, 0);
    check("empty_clr", 32'(const_empty), 32'h1);

    cycle("clr_ld", 1, 8'h7A, 0, 1, 1);
    check("c007a", 32'(const_value), 32'h007A);
    cycle("clr_rd", 1, 8'h55, 1, 1, 0);

    cycle("ld_rd", 1, 8'hC3, 1, 0, 1);
    do_reset("rst_mid");
    check("c_rst", 32'(const_value), 32'h0);

    for (int n = 0; n < 400; n++) begin
      cycle("rand",
            1'($urandom_range(0, 99) < 45),
            8'($urandom),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 12),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
